// File: rtl/conv_pool_flatten_if.sv
// Start/busy handshake plus the shared layer-memory bus (read, write, bank select)
// of the conv max-pool/flatten engine.
interface conv_pool_flatten_if #(
    parameter int DW = 20,
    parameter int AW = 12,
    parameter int SW = 3
);
    logic          ready;
    logic          busy;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic [SW-1:0] csel;

    modport master (
        input  ready, cdata_rd,
        output busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );

    modport slave (
        output ready, cdata_rd,
        input  busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );
endinterface

// File: rtl/conv_pool_flatten.sv
// 2x2/stride-2 max-pool (optional ReLU and integer ceil) over CH channels, writing each
// pooled value to its per-channel L1 bank and to the channel-interleaved L2 bank.
module conv_pool_flatten #(
    parameter int DW       = 20,
    parameter int FRAC     = 4,
    parameter int IMG_W    = 64,
    parameter int CH       = 2,
    parameter int ROUND_UP = 1,
    parameter int RELU_IN  = 0
) (
    input  logic                clk,
    input  logic                reset,
    conv_pool_flatten_if.master bus
);
    localparam int LP = $clog2(IMG_W) - 1;
    localparam int AW = 2 * $clog2(IMG_W);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    // csel gains a 4th bit only when CH=4 pushes the L1/L2 bank numbers past 7
    localparam int SW = (CH > 2) ? 4 : 3;

    localparam logic [DW:0]   RND_ADD = (DW+1)'((1 << FRAC) - 1);
    localparam logic [DW-1:0] SAT_VAL = {1'b0, {(DW-1-FRAC){1'b1}}, {FRAC{1'b0}}};

    typedef enum logic [2:0] {IDLE, RD, WL1, WL2, DONE} state_t;

    state_t               state_q, state_n;
    logic [2:0]           sub_q;
    logic [LP-1:0]        row_q, col_q;
    logic [CW-1:0]        ch_q;
    logic signed [DW-1:0] max_q, sample, max_nx;
    logic [DW-1:0]        res_q, pooled;
    logic [DW:0]          rnd_sum;
    logic [AW-1:0]        rd_addr, rd_hold_q, wr_addr_q, l2_addr;
    logic [AW-3:0]        pix;
    logic                 busy, crd, cwr, last;
    logic [SW-1:0]        csel;

    always_comb begin
        state_n = state_q;
        busy    = 1'b0;
        crd     = 1'b0;
        cwr     = 1'b0;
        csel    = '0;
        last    = (ch_q == CW'(CH - 1)) && (row_q == '1) && (col_q == '1);
        case (state_q)
            IDLE: if (bus.ready) state_n = RD;
            RD: begin
                busy = 1'b1;
                crd  = (sub_q != 3'd4);
                csel = SW'(ch_q) + SW'(1);
                if (sub_q == 3'd4) state_n = WL1;
            end
            WL1: begin
                busy    = 1'b1;
                cwr     = 1'b1;
                csel    = SW'(ch_q) + SW'(1 + CH);
                state_n = WL2;
            end
            WL2: begin
                busy    = 1'b1;
                cwr     = 1'b1;
                csel    = SW'(1 + 2 * CH);
                state_n = last ? DONE : RD;
            end
            DONE: begin
                busy    = 1'b1;
                csel    = SW'(1 + 2 * CH);
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Window sample order {0,1,W,W+1} is just the sub-count bits spliced into row/col
    always_comb begin
        rd_addr = {row_q, sub_q[1], col_q, sub_q[0]};
        pix     = {row_q, col_q};
        l2_addr = AW'(pix) * AW'(CH) + AW'(ch_q);
        sample  = (RELU_IN != 0 && bus.cdata_rd[DW-1]) ? '0 : bus.cdata_rd;
        max_nx  = (sub_q == 3'd1 || sample > max_q) ? sample : max_q;
        rnd_sum = ({max_nx[DW-1], max_nx} + RND_ADD) & ~RND_ADD;
        if (ROUND_UP == 0)
            pooled = max_nx;
        else if (!rnd_sum[DW] && rnd_sum[DW-1])
            pooled = SAT_VAL;
        else
            pooled = rnd_sum[DW-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sub_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            ch_q      <= '0;
            max_q     <= '0;
            res_q     <= '0;
            rd_hold_q <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q <= state_n;
            if (crd) rd_hold_q <= rd_addr;
            case (state_q)
                RD: begin
                    sub_q <= (sub_q == 3'd4) ? '0 : sub_q + 3'd1;
                    if (sub_q != 3'd0) max_q <= max_nx;
                    if (sub_q == 3'd4) begin
                        res_q     <= pooled;
                        wr_addr_q <= AW'(pix);
                    end
                end
                WL1: wr_addr_q <= l2_addr;
                WL2: begin
                    col_q <= col_q + 1'b1;
                    if (col_q == '1) begin
                        row_q <= row_q + 1'b1;
                        if (row_q == '1) ch_q <= (ch_q == CW'(CH - 1)) ? '0 : ch_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.crd      = crd;
    assign bus.cwr      = cwr;
    assign bus.csel     = csel;
    assign bus.caddr_rd = crd ? rd_addr : rd_hold_q;
    assign bus.caddr_wr = wr_addr_q;
    assign bus.cdata_wr = res_q;
endmodule

// File: tb/tb_conv_pool_flatten.sv
// Directed and full-frame checks of conv_pool_flatten over four parameter sets, each
// with its own L0 memory model and L1/L2 write scoreboard.
module tb_conv_pool_flatten;
    localparam int DW = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic ready_v [4];
    logic go [4];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int cfg_w(int g);
        case (g) 0: return 64; 1: return 8; 2: return 4; default: return 16; endcase
    endfunction
    function automatic int cfg_ch(int g);
        case (g) 0: return 2; 1: return 1; 2: return 1; default: return 4; endcase
    endfunction
    function automatic int cfg_rnd(int g);
        return (g == 2) ? 0 : 1;
    endfunction
    function automatic int cfg_relu(int g);
        return (g == 2) ? 1 : 0;
    endfunction

    // L0 contents: ramp pattern for set 0, hand-picked corner windows for sets 1/2, else hash
    function automatic logic [19:0] l0_val(int g, int c, int a);
        int unsigned x;
        if (g == 0) return (c == 0) ? 20'(a << 4) : 20'((4095 - a) << 4);
        if (g == 1) begin
            case (a)
                0: return 20'h00011;
                1: return 20'h00003;
                8, 9: return 20'h00000;
                2, 3, 10, 11: return 20'h00010;
                4, 5, 12, 13: return 20'hFFFF8;
                6, 15: return 20'h7FFF1;
                7: return 20'h00005;
                14: return 20'h80000;
                default: ;
            endcase
        end
        if (g == 2) begin
            case (a)
                0: return 20'h7FFF1;
                1: return 20'h00000;
                4: return 20'h80000;
                5: return 20'h00005;
                2: return 20'hFFFF8;
                3: return 20'h80000;
                6: return 20'hFFFFF;
                7: return 20'hFFFF0;
                8: return 20'h00013;
                9: return 20'hFFFFF;
                12: return 20'h00011;
                13: return 20'h00012;
                default: ;
            endcase
        end
        x = 32'(a) * 32'h9E3779B1 + 32'(g) * 32'h85EBCA77 + 32'(c) * 32'hC2B2AE3D + 32'h1234567;
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x[19:0];
    endfunction

    function automatic logic [19:0] gold(int g, int c, int r, int k);
        int w, base, best, v;
        logic [19:0] d;
        w    = cfg_w(g);
        base = 2 * r * w + 2 * k;
        best = 0;
        for (int i = 0; i < 4; i++) begin
            d = l0_val(g, c, base + (i / 2) * w + (i % 2));
            v = {{12{d[19]}}, d};
            if (cfg_relu(g) != 0 && v < 0) v = 0;
            if (i == 0 || v > best) best = v;
        end
        if (cfg_rnd(g) != 0) begin
            if (best >= 0) best = ((best + 15) / 16) * 16;
            else           best = -(((-best) / 16) * 16);
            if (best > 524287) best = 524272;
        end
        return best[19:0];
    endfunction

    for (genvar g = 0; g < 4; g++) begin : u_gen
        localparam int  GI   = g;
        localparam int  W    = cfg_w(g);
        localparam int  C    = cfg_ch(g);
        localparam int  P    = W / 2;
        localparam int  NP   = P * P;
        localparam int  AW   = 2 * $clog2(W);
        localparam int  SW   = (C > 2) ? 4 : 3;
        localparam bit  HOLD = (g == 0 || g == 3);

        conv_pool_flatten_if #(.DW(DW), .AW(AW), .SW(SW)) bus ();

        conv_pool_flatten #(
            .DW(DW), .FRAC(4), .IMG_W(W), .CH(C),
            .ROUND_UP(cfg_rnd(g)), .RELU_IN(cfg_relu(g))
        ) u_dut (
            .clk  (clk),
            .reset(rst_n),
            .bus  (bus)
        );

        logic [DW-1:0] l1 [C*NP];
        int            l1_cnt [C*NP];
        logic [DW-1:0] l2 [C*NP];
        int            l2_cnt [C*NP];
        int            busy_cycles;
        int            proto_err;

        assign bus.ready = ready_v[g];

        always @(posedge clk) begin
            int a, s;
            if (bus.ready && !bus.busy) begin
                for (int i = 0; i < C * NP; i++) begin
                    l1_cnt[i] = 0;
                    l2_cnt[i] = 0;
                end
                busy_cycles = 0;
                proto_err   = 0;
            end
            if (bus.busy) busy_cycles++;
            if (bus.crd && bus.cwr) proto_err++;
            if (bus.crd) bus.cdata_rd <= l0_val(GI, int'(bus.csel) - 1, int'(bus.caddr_rd));
            if (bus.cwr) begin
                a = int'(bus.caddr_wr);
                s = int'(bus.csel);
                if (s == 1 + 2 * C && a < C * NP) begin
                    l2[a] = bus.cdata_wr;
                    l2_cnt[a]++;
                end else if (s > C && s <= 2 * C && a < NP) begin
                    l1[(s - 1 - C) * NP + a] = bus.cdata_wr;
                    l1_cnt[(s - 1 - C) * NP + a]++;
                end else begin
                    proto_err++;
                end
            end
        end

        initial begin
            ready_v[g] = 1'b0;
            forever begin
                int n, c, p, r, k;
                wait (go[g]);
                @(negedge clk);
                ready_v[g] = 1'b1;
                n = 0;
                while (!bus.busy && n < 8) begin @(negedge clk); n++; end
                if (!HOLD) ready_v[g] = 1'b0;
                n = 0;
                while (bus.busy && n < 7 * C * NP + 20) begin @(negedge clk); n++; end
                ready_v[g] = 1'b0;
                check($sformatf("g%0d frame_end", GI), 32'(bus.busy), 32'd0);
                check($sformatf("g%0d busy_cycles", GI), 32'(busy_cycles), 32'(7 * C * NP + 1));
                check($sformatf("g%0d proto", GI), 32'(proto_err), 32'd0);
                for (int i = 0; i < C * NP; i++) begin
                    c = i / NP;
                    p = i % NP;
                    r = p / P;
                    k = p % P;
                    check($sformatf("g%0d l1_cnt[%0d]", GI, i), 32'(l1_cnt[i]), 32'd1);
                    check($sformatf("g%0d l1[%0d]", GI, i), 32'(l1[i]), 32'(gold(GI, c, r, k)));
                    check($sformatf("g%0d l2_cnt[%0d]", GI, p * C + c), 32'(l2_cnt[p * C + c]), 32'd1);
                    check($sformatf("g%0d l2[%0d]", GI, p * C + c), 32'(l2[p * C + c]), 32'(gold(GI, c, r, k)));
                end
                go[g] = 1'b0;
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 4; i++) go[i] = 1'b0;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) ready_v[i] = 1'b1;
        #1;
        check("rst_busy", 32'(u_gen[0].bus.busy), 32'd0);
        check("rst_crd", 32'(u_gen[0].bus.crd), 32'd0);
        check("rst_cwr", 32'(u_gen[0].bus.cwr), 32'd0);
        check("rst_csel", 32'(u_gen[0].bus.csel), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_hold_busy", 32'(u_gen[3].bus.busy), 32'd0);
        for (int i = 0; i < 4; i++) ready_v[i] = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) go[i] = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", 32'(u_gen[0].bus.busy), 32'd0);
        @(posedge clk); #1;
        check("acc_busy", 32'(u_gen[0].bus.busy), 32'd1);
        check("acc_crd", 32'(u_gen[0].bus.crd), 32'd1);
        check("acc_raddr", 32'(u_gen[0].bus.caddr_rd), 32'd0);
        check("acc_csel", 32'(u_gen[0].bus.csel), 32'd1);
        repeat (4) @(posedge clk); #1;
        check("s4_crd", 32'(u_gen[0].bus.crd), 32'd0);
        check("s4_raddr_hold", 32'(u_gen[0].bus.caddr_rd), 32'd65);
        @(posedge clk); #1;
        check("wl1_cwr", 32'(u_gen[0].bus.cwr), 32'd1);
        check("wl1_csel", 32'(u_gen[0].bus.csel), 32'd3);
        check("wl1_addr", 32'(u_gen[0].bus.caddr_wr), 32'd0);
        check("wl1_data", 32'(u_gen[0].bus.cdata_wr), 32'h00410);
        @(posedge clk); #1;
        check("wl2_csel", 32'(u_gen[0].bus.csel), 32'd5);
        check("wl2_data", 32'(u_gen[0].bus.cdata_wr), 32'h00410);
        @(posedge clk); #1;
        check("rd1_raddr", 32'(u_gen[0].bus.caddr_rd), 32'd2);
        check("rd1_wdata_hold", 32'(u_gen[0].bus.cdata_wr), 32'h00410);

        n = 0;
        while ((go[0] || go[1] || go[2] || go[3]) && n < 20000) begin @(negedge clk); n++; end
        check("frames_done", 32'(go[0] || go[1] || go[2] || go[3]), 32'd0);

        check("pat_l1c1", 32'(u_gen[0].l1[1024]), 32'h0FFF0);
        check("pat_l2_1", 32'(u_gen[0].l2[1]), 32'h0FFF0);
        check("pat_l2_0", 32'(u_gen[0].l2[0]), 32'h00410);
        check("rnd_ceil", 32'(u_gen[1].l1[0]), 32'h00020);
        check("rnd_exact", 32'(u_gen[1].l1[1]), 32'h00010);
        check("rnd_neg_half", 32'(u_gen[1].l1[2]), 32'h00000);
        check("rnd_sat", 32'(u_gen[1].l1[3]), 32'h7FFF0);
        check("nornd_max", 32'(u_gen[2].l1[0]), 32'h7FFF1);
        check("relu_neg", 32'(u_gen[2].l1[1]), 32'h00000);
        check("nornd_frac", 32'(u_gen[2].l1[2]), 32'h00013);

        @(negedge clk);
        ready_v[0] = 1'b1;
        @(negedge clk);
        ready_v[0] = 1'b0;
        n = 0;
        while (u_gen[0].busy_cycles < 500 && n < 1000) begin @(negedge clk); n++; end
        check("abort_busy", 32'(u_gen[0].bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy0", 32'(u_gen[0].bus.busy), 32'd0);
        check("abort_crd", 32'(u_gen[0].bus.crd), 32'd0);
        check("abort_cwr", 32'(u_gen[0].bus.cwr), 32'd0);
        check("abort_csel", 32'(u_gen[0].bus.csel), 32'd0);
        check("abort_raddr", 32'(u_gen[0].bus.caddr_rd), 32'd0);
        check("abort_waddr", 32'(u_gen[0].bus.caddr_wr), 32'd0);
        check("abort_wdata", 32'(u_gen[0].bus.cdata_wr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        go[0] = 1'b1;
        n = 0;
        while (go[0] && n < 16000) begin @(negedge clk); n++; end
        check("rerun_done", 32'(go[0]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
